// File: rtl/paridade_pkg.sv
// paridade_pkg: shared FSM encodings and reduction-XOR helper for the parity blocks
// Contents:
//   IDLE/ACC/HOLD  frame FSM state encodings
//   PAR_MAXW       widest word red_xor accepts
//   red_xor        parity of a word, zero-extended by the caller to PAR_MAXW
package paridade_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam int PAR_MAXW = 256;
  // Zero-extension leaves the parity unchanged, so any width up to PAR_MAXW can share this function
  function automatic logic red_xor(input logic [PAR_MAXW-1:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/paridade_frame.sv
// paridade_frame: frame-level even/odd parity generator/checker on a valid/ready stream
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   data_in, in_valid, in_last, in_ready   word stream in (in_ready decoded from state)
//   odd_sel, chk_en           mode selects, latched on the first beat of a frame
//   par_in                    received parity, sampled on the last beat only
//   out_valid, out_ready      result handshake
//   parity_out, par_err       registered frame result
//   err_count, err_clr        saturating error counter and its synchronous clear
module paridade_frame
  import paridade_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             odd_sel,
  input  logic             chk_en,
  input  logic             par_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             parity_out,
  output logic             par_err,
  output logic [CNT_W-1:0] err_count,
  input  logic             err_clr
);
  logic [1:0] state_q, state_d;
  logic acc_q, odd_q, chk_q, ov_q, po_q, pe_q;
  logic [CNT_W-1:0] cnt_q;
  logic beat, fin, first, acc_n, odd_m, chk_m, par_n, err_n;
  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == HOLD ? (out_ready ? IDLE : HOLD)
            : beat ? (in_last ? HOLD : ACC) : state_q;
  always_comb in_ready = state_q != HOLD;
  // On the first beat the accumulator and modes come straight from the inputs, so no stale frame leaks in
  always_comb begin
    beat  = in_valid & in_ready;
    fin   = beat & in_last;
    first = state_q == IDLE;
    acc_n = (first ? 1'b0 : acc_q) ^ red_xor(PAR_MAXW'(data_in));
    odd_m = first ? odd_sel : odd_q;
    chk_m = first ? chk_en : chk_q;
    par_n = acc_n ^ odd_m;
    err_n = chk_m & (par_n ^ par_in);
  end
  always_ff @(posedge clk)
    if (rst) begin
      acc_q <= 1'b0;
      odd_q <= 1'b0;
      chk_q <= 1'b0;
      ov_q  <= 1'b0;
      po_q  <= 1'b0;
      pe_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= beat ? acc_n : acc_q;
      odd_q <= odd_m;
      chk_q <= chk_m;
      ov_q  <= fin ? 1'b1 : (ov_q & out_ready) ? 1'b0 : ov_q;
      po_q  <= fin ? par_n : po_q;
      pe_q  <= fin ? err_n : pe_q;
      cnt_q <= err_clr ? '0 : (fin & err_n & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
    end
  assign out_valid  = ov_q;
  assign parity_out = po_q;
  assign par_err    = pe_q;
  assign err_count  = cnt_q;
endmodule

// File: tb/tb_paridade_frame.sv
// tb_paridade_frame: directed-vector bench for paridade_frame (CNT_W=2 to reach saturation)
module tb_paridade_frame;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] data_in = '0;
  logic in_valid = 1'b0, in_last = 1'b0, odd_sel = 1'b0, chk_en = 1'b0, par_in = 1'b0;
  logic out_ready = 1'b0, err_clr = 1'b0;
  logic in_ready, out_valid, parity_out, par_err;
  logic [1:0] err_count;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  paridade_frame #(.WIDTH(8), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .odd_sel(odd_sel), .chk_en(chk_en), .par_in(par_in),
    .out_valid(out_valid), .out_ready(out_ready), .parity_out(parity_out),
    .par_err(par_err), .err_count(err_count), .err_clr(err_clr)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [7:0] d, input logic l, input logic p);
    data_in = d; in_last = l; par_in = p; in_valid = 1'b1;
    tick;
    in_valid = 1'b0; in_last = 1'b0;
  endtask
  task automatic take;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("take_ov", out_valid, 0);
    chk("take_rdy", in_ready, 1);
  endtask
  initial begin
    tick; tick;
    chk("rst_ov", out_valid, 0);
    chk("rst_par", parity_out, 0);
    chk("rst_err", par_err, 0);
    chk("rst_cnt", err_count, 0);
    rst = 1'b0;
    tick;
    chk("rst_rdy", in_ready, 1);
    // single-word frames, even then odd
    beat(8'h01, 1, 0);
    chk("s_even_ov", out_valid, 1);
    chk("s_even_par", parity_out, 1);
    chk("s_even_err", par_err, 0);
    chk("s_even_rdy", in_ready, 0);
    take;
    odd_sel = 1'b1;
    beat(8'h01, 1, 0);
    chk("s_odd_par", parity_out, 0);
    take;
    // three-word frame, 9 ones
    odd_sel = 1'b0;
    beat(8'h03, 0, 0);
    chk("m_ov0", out_valid, 0);
    beat(8'h07, 0, 0);
    beat(8'h0F, 1, 0);
    chk("m_par", parity_out, 1);
    take;
    // same frame with gaps, a stray in_last without valid, and odd_sel toggled mid-frame
    beat(8'h03, 0, 0);
    in_last = 1'b1;
    tick; tick;
    in_last = 1'b0;
    chk("g_ov0", out_valid, 0);
    chk("g_rdy", in_ready, 1);
    odd_sel = 1'b1;
    beat(8'h07, 0, 0);
    beat(8'h0F, 1, 0);
    chk("g_par", parity_out, 1);
    take;
    odd_sel = 1'b0;
    // check mode
    chk_en = 1'b1;
    beat(8'hFF, 1, 1);
    chk("c_par", parity_out, 0);
    chk("c_err", par_err, 1);
    chk("c_cnt", err_count, 1);
    take;
    beat(8'hFF, 1, 0);
    chk("c2_err", par_err, 0);
    chk("c2_cnt", err_count, 1);
    take;
    // saturation
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    chk("clr_cnt", err_count, 0);
    for (int i = 0; i < 5; i++) begin
      beat(8'hFF, 1, 1);
      chk("sat_cnt", err_count, (i < 3) ? i + 1 : 3);
      take;
    end
    err_clr = 1'b1;
    beat(8'hFF, 1, 1);
    err_clr = 1'b0;
    chk("clrwin_err", par_err, 1);
    chk("clrwin_cnt", err_count, 0);
    take;
    // backpressure
    chk_en = 1'b0;
    beat(8'h01, 1, 0);
    data_in = 8'h00; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("bp_ov", out_valid, 1);
      chk("bp_rdy", in_ready, 0);
      chk("bp_par", parity_out, 1);
    end
    in_valid = 1'b0; in_last = 1'b0;
    take;
    tick;
    chk("bp_idle_ov", out_valid, 0);
    // reset mid-frame
    chk_en = 1'b1;
    beat(8'hFF, 1, 1);
    chk("pre_cnt", err_count, 1);
    take;
    chk_en = 1'b0;
    beat(8'h01, 0, 0);
    beat(8'h03, 0, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mr_ov", out_valid, 0);
    chk("mr_cnt", err_count, 0);
    chk("mr_rdy", in_ready, 1);
    beat(8'h01, 1, 0);
    chk("mr_ov1", out_valid, 1);
    chk("mr_par", parity_out, 1);
    take;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/paridade_frame.md
# paridade_frame

Parametrised, clocked successor to the combinational byte-parity generator. It accumulates even or odd parity across a multi-word frame delivered on a valid/ready stream. It presents one registered parity result per frame, with its own handshake. In check mode it compares the result against a received parity bit and keeps a saturating error count. It sits between a word source (serial deserialiser or bus) and the frame-integrity logic.

## Interface
- WIDTH, 8: data word width in bits (≥1)
- CNT_W, 8: error counter width in bits (≥1)

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- data_in  in  WIDTH  input word
- in_valid  in  1  data_in/in_last/par_in are valid
- in_last  in  1  marks final word of frame
- in_ready  out  1  block accepts a word this cycle
- odd_sel  in  1  0 = even parity, 1 = odd parity; sampled on first beat of frame
- chk_en  in  1  1 = check mode; sampled on first beat of frame
- par_in  in  1  received parity bit; sampled on the last beat only
- out_valid  out  1  frame result held on outputs
- out_ready  in  1  consumer takes result
- parity_out  out  1  computed frame parity
- par_err  out  1  parity_out != par_in (check mode), else 0
- err_count  out  CNT_W  saturating count of frames with par_err=1
- err_clr  in  1  synchronous clear of err_count

## Operation
- Beat accepted when in_valid & in_ready.
- Accumulator acc holds the XOR of the reduction-XOR of every accepted word in the current frame.
- parity_out = acc_final ^ odd_mode.
  - Even mode: total ones including the parity bit is even.
  - Odd mode: that total is odd.
- odd_mode and chk_mode are latched on the first beat of a frame. Changes on odd_sel/chk_en mid-frame are ignored until the next frame.
- FSM states:
  - IDLE: no frame open. in_ready=1.
    - Accepted beat with in_last=0 → ACC.
    - Accepted beat with in_last=1 → HOLD (single-word frame).
  - ACC: frame open. in_ready=1.
    - Accepted beat with in_last=1 → HOLD.
    - in_valid=0 → stay; acc unchanged.
  - HOLD: out_valid=1, in_ready=0. Outputs stable until out_valid & out_ready, then → IDLE.
- par_err = chk_mode & (parity_out ^ par_in_latched). It is forced to 0 in generate mode.
- err_count increments by 1 on the cycle HOLD is entered with par_err=1. It saturates at 2^CNT_W−1 and never wraps.
- err_clr=1 forces err_count to 0. When err_clr coincides with an increment, clear wins (result 0).

## Timing
- Reset (rst=1 at a clock edge) forces:
  - state=IDLE, acc=0
  - out_valid=0, parity_out=0, par_err=0, err_count=0
  - in_ready=1 from the following cycle
- Reset mid-frame or in HOLD discards the partial or pending result. No err_count update occurs.
- Latency: out_valid, parity_out and par_err are asserted on the clock edge after the last beat is accepted (1 cycle).
- All outputs are registered except in_ready, which is decoded from state.
- Throughput:
  - One word per cycle within a frame.
  - Each frame costs at least one HOLD cycle, during which in_ready=0.
  - The first beat of the next frame is accepted no earlier than the cycle after the out handshake.
- in_last with in_valid=0 has no effect.
- par_in is ignored on non-last beats.

## Structure
- Shared package paridade_pkg holds:
  - the FSM state encodings as localparams (IDLE=2'd0, ACC=2'd1, HOLD=2'd2)
  - a reduction-XOR function parameterised by width, reusable by the existing parity block
- No sub-module: a single-file FSM plus datapath, about 150–250 lines.

## Test plan
- Single-word frame 8'h01, even mode → parity_out=1, par_err=0, out_valid one cycle after the beat. Repeat in odd mode → parity_out=0.
- Frame 8'h03, 8'h07, 8'h0F (9 ones), even mode → parity_out=1. With in_valid gaps inserted mid-frame → same result.
- Check mode, frame 8'hFF (8 ones), even, par_in=1 → parity_out=0, par_err=1, err_count=1. Next frame with par_in=0 → par_err=0, err_count stays 1.
- Saturation and clear:
  - CNT_W=2, five consecutive erroneous frames → err_count 1,2,3,3,3.
  - err_clr asserted on an incrementing cycle → err_count=0.
- Backpressure:
  - out_ready=0 for 4 cycles in HOLD → outputs stable, in_ready=0, new beats not accepted.
  - out_ready=1 → IDLE next cycle.
  - Toggling odd_sel mid-frame does not change the result.
- Reset mid-frame after 2 words → out_valid=0, err_count=0. The next frame 8'h01 alone yields parity_out=1 in even mode (no residue from the aborted frame).
